// File: rtl/addsub_share_ctrl.sv
// addsub_share_ctrl: round-robin sharing of one WIDTH-bit adder between two add/sub requesters
// Ports: clk/rst (async, active-high); req{0,1}_valid/ready/op/a/b operation channels;
// rsp{0,1}_valid/ready per-requester response handshakes; rsp_data/rsp_flag shared result bus.
module addsub_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, op_q, op_d, flag_q, flag_d, grant, cy32;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, x, y, s;
  // last_q doubles as the owner of the operation in flight
  assign grant = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = (state_q == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state_q == IDLE) & grant;
  assign rsp0_valid = (state_q == RESP) & ~last_q;
  assign rsp1_valid = (state_q == RESP) & last_q;
  assign rsp_data = acc_q;
  assign rsp_flag = flag_q;
  // the single shared adder: pass 1 adds a and b (or ~b), pass 2 adds the +1 of the two's complement
  assign x = (state_q == PASS2) ? acc_q : a_q;
  assign y = (state_q == PASS2) ? WIDTH'(1) : (op_q ? ~b_q : b_q);
  assign {cy32, s} = {1'b0, x} + {1'b0, y};
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    flag_d = flag_q;
    case (state_q)
      IDLE: if (req0_valid | req1_valid) begin
        state_d = PASS1;
        last_d = grant;
        op_d = grant ? req1_op : req0_op;
        a_d = grant ? req1_a : req0_a;
        b_d = grant ? req1_b : req0_b;
      end
      PASS1: begin
        acc_d = s;
        flag_d = cy32;
        state_d = op_q ? PASS2 : RESP;
      end
      PASS2: begin
        acc_d = s;
        // a >= b iff either pass of a + ~b + 1 carried out
        flag_d = flag_q | cy32;
        state_d = RESP;
      end
      RESP: state_d = (last_q ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      op_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      flag_q <= flag_d;
    end
  end
endmodule

// File: tb/tb_addsub_share_ctrl.sv
// tb_addsub_share_ctrl: directed self-checking bench for addsub_share_ctrl
module tb_addsub_share_ctrl;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req0_op = 0, req1_valid = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp0_ready = 1, rsp1_ready = 1;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_flag;
  logic [31:0] rsp_data;
  int checks = 0, errors = 0;

  addsub_share_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one operation from a single requester; lat = edges from accept to response visible
  task automatic do_op(input string tag, input logic port, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] exp_d, input logic exp_f);
    if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk({tag, "_ready"}, port ? req1_ready : req0_ready, 1);
    chk({tag, "_other_ready"}, port ? req0_ready : req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    req0_a = 32'hDEADBEEF; req0_b = 32'h12345678; req1_a = 32'hCAFEF00D; req1_b = 32'h0F0F0F0F;
    req0_op = ~op; req1_op = ~op;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_early_valid"}, port ? rsp1_valid : rsp0_valid, 0);
      step();
    end
    chk({tag, "_valid"}, port ? rsp1_valid : rsp0_valid, 1);
    chk({tag, "_other_valid"}, port ? rsp0_valid : rsp1_valid, 0);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_flag"}, rsp_flag, exp_f);
    step();
    chk({tag, "_done"}, port ? rsp1_valid : rsp0_valid, 0);
  endtask

  initial begin
    #1;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_flag", rsp_flag, 0);
    step();
    step();
    rst = 0;
    step();
    // T1..T3 basic arithmetic and wrap-around
    do_op("add_5_7", 0, 0, 32'd5, 32'd7, 2, 32'h0000000C, 0);
    do_op("sub_3_5", 1, 1, 32'd3, 32'd5, 3, 32'hFFFFFFFE, 0);
    do_op("sub_5_5", 0, 1, 32'd5, 32'd5, 3, 32'h00000000, 1);
    do_op("add_wrap", 1, 0, 32'hFFFFFFFF, 32'h1, 2, 32'h00000000, 1);
    do_op("sub_0_0", 0, 1, 32'd0, 32'd0, 3, 32'h00000000, 1);
    do_op("sub_b0", 1, 1, 32'h80000001, 32'd0, 3, 32'h80000001, 1);
    // T5 response back-pressure
    rsp0_ready = 0;
    req0_valid = 1; req0_op = 0; req0_a = 32'd10; req0_b = 32'd20;
    step();
    req0_valid = 0;
    req1_valid = 1; req1_op = 0; req1_a = 32'd1; req1_b = 32'd1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp0_valid, 1);
      chk("hold_data", rsp_data, 32'h1E);
      chk("hold_flag", rsp_flag, 0);
      chk("hold_req1_ready", req1_ready, 0);
      chk("hold_rsp1_valid", rsp1_valid, 0);
      step();
    end
    rsp0_ready = 1;
    step();
    chk("release_rsp0_valid", rsp0_valid, 0);
    chk("release_req1_ready", req1_ready, 1);
    req1_valid = 0;
    step();
    chk("withdraw_req1_ready", req1_ready, 0);
    chk("withdraw_rsp1_valid", rsp1_valid, 0);
    // T6 reset during PASS2
    req1_valid = 1; req1_op = 1; req1_a = 32'd9; req1_b = 32'd4;
    step();
    req1_valid = 0;
    step();
    chk("pass2_acc", rsp_data, 32'h4);
    rst = 1;
    #1;
    chk("arst_data", rsp_data, 0);
    chk("arst_flag", rsp_flag, 0);
    chk("arst_rsp1_valid", rsp1_valid, 0);
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_rsp1_valid", rsp1_valid, 0);
      chk("post_rst_rsp0_valid", rsp0_valid, 0);
      step();
    end
    // T4 both requesting continuously: round-robin starting at r0
    req0_valid = 1; req0_op = 0; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1; req1_op = 1; req1_a = 32'd10; req1_b = 32'd3;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_req0_ready", req0_ready, (k % 2) == 0);
      chk("rr_req1_ready", req1_ready, (k % 2) == 1);
      step();
      chk("rr_busy_req0_ready", req0_ready, 0);
      chk("rr_busy_req1_ready", req1_ready, 0);
      repeat ((k % 2) ? 2 : 1) step();
      chk("rr_rsp0_valid", rsp0_valid, (k % 2) == 0);
      chk("rr_rsp1_valid", rsp1_valid, (k % 2) == 1);
      chk("rr_data", rsp_data, (k % 2) ? 32'd7 : 32'd3);
      chk("rr_flag", rsp_flag, (k % 2) ? 1 : 0);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
